// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for a sequential shift-add multiplier: load, then WIDTH add/shift pairs, then done.
// Optional macro MULT_CTRL_DONE_HOLD_EN keeps DONE asserted until start is released (four-phase handshake).
module shift_add_mult_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             q0,
  output logic             ld_a,
  output logic             ld_q,
  output logic             clr_p,
  output logic             ld_p,
  output logic             sh_pq,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  // Handshake: start is a request sampled only in IDLE; done marks {P,Q} valid.
  // Requests seen while busy or in DONE are dropped, never queued.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] iter_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      iter  <= '0;
    end else begin
      state <= state_nxt;
      iter  <= iter_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    iter_nxt  = iter;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_ADD;
        iter_nxt  = '0;
      end
      S_ADD: begin
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (iter == LAST_ITER) begin
          state_nxt = S_DONE;
          iter_nxt  = '0;
        end else begin
          state_nxt = S_ADD;
          iter_nxt  = iter + CNT_W'(1);
        end
      end
      S_DONE: begin
`ifdef MULT_CTRL_DONE_HOLD_EN
        if (!start) state_nxt = S_IDLE;
`else
        state_nxt = S_IDLE;
`endif
      end
      default: begin
        state_nxt = S_IDLE;
        iter_nxt  = '0;
      end
    endcase
  end

  // ld_p is the only output that looks past the state, gating the add on the multiplier LSB.
  always_comb begin
    ld_a  = 1'b0;
    ld_q  = 1'b0;
    clr_p = 1'b0;
    ld_p  = 1'b0;
    sh_pq = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_LOAD: begin
        ld_a  = 1'b1;
        ld_q  = 1'b1;
        clr_p = 1'b1;
        busy  = 1'b1;
      end
      S_ADD: begin
        ld_p = q0;
        busy = 1'b1;
      end
      S_SHIFT: begin
        sh_pq = 1'b1;
        busy  = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: bench-side datapath, run-position reference model, directed and random runs.
module tb_shift_add_mult_ctrl;

  localparam int W        = 4;
  localparam int CW       = $clog2(W);
  localparam int W2       = 2 * W;
  localparam int DONE_POS = 2 * W + 1;

  // clock/reset block
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic q0;
  logic ld_a, ld_q, clr_p, ld_p, sh_pq, busy, done;
  logic [CW-1:0] iter;

  always #5 clk = ~clk;

  shift_add_mult_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .q0    (q0),
    .ld_a  (ld_a),
    .ld_q  (ld_q),
    .clr_p (clr_p),
    .ld_p  (ld_p),
    .sh_pq (sh_pq),
    .busy  (busy),
    .done  (done),
    .iter  (iter)
  );

  // bench datapath: A, Q, P plus adder carry
  logic [W-1:0] a_bus, q_bus, a_r, p_r, q_r;
  logic         c_r;
  logic [W2:0]  cpq;

  assign q0 = q_r[0];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0; p_r <= '0; q_r <= '0; c_r <= 1'b0;
    end else begin
      if (ld_a) a_r <= a_bus;
      if (ld_q) q_r <= q_bus;
      if (clr_p) {c_r, p_r} <= '0;
      if (ld_p) {c_r, p_r} <= {1'b0, p_r} + {1'b0, a_r};
      if (sh_pq) begin
        cpq = {c_r, p_r, q_r} >> 1;
        {c_r, p_r, q_r} <= cpq;
      end
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [W2-1:0] exp_q[$];
  int pos = -1;
  bit prod_checked = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pos = cycles since LOAD (-1 when idle); outputs follow from pos arithmetic.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos = -1;
      exp_q.delete();
    end else begin
      if (pos == 0) exp_q.push_back(W2'(a_bus) * W2'(q_bus));
      if (pos == -1) begin
        if (start) pos = 0;
      end else if (pos < DONE_POS) begin
        pos++;
      end else begin
`ifdef MULT_CTRL_DONE_HOLD_EN
        if (!start) pos = -1;
`else
        pos = -1;
`endif
      end
    end
  end

  function automatic logic [31:0] exp_vec(input int p, input logic lsb);
    logic ld, ad, sh, bz, dn;
    logic [CW-1:0] it;
    ld = (p == 0);
    ad = (p >= 1) && (p <= 2 * W) && (p % 2 == 1);
    sh = (p >= 2) && (p <= 2 * W) && (p % 2 == 0);
    bz = (p >= 0) && (p <= 2 * W);
    dn = (p == DONE_POS);
    it = (ad || sh) ? CW'((p - 1) / 2) : '0;
    return 32'({ld, ld, ld, ad & lsb, sh, bz, dn, it});
  endfunction

  function automatic logic [31:0] act_vec();
    return 32'({ld_a, ld_q, clr_p, ld_p, sh_pq, busy, done, iter});
  endfunction

  // compare process
  always @(negedge clk) begin
    if (!rst) begin
      chk("cycle_outputs", act_vec(), exp_vec(pos, q_r[0]));
      if (pos == DONE_POS && !prod_checked) begin
        prod_checked = 1'b1;
        if (exp_q.size() == 0) chk("product_queue_empty", 32'd1, 32'd0);
        else chk("product", 32'({p_r, q_r}), 32'(exp_q.pop_front()));
      end
      if (pos != DONE_POS) prod_checked = 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    a_bus = W'($urandom);
    q_bus = W'($urandom);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pos == -1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", 32'(ok), 32'd1);
    tick();
  endtask

  // start pulse at edge 0, then literal per-cycle expectations for cycles 1..11
  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] q,
                          input logic [W-1:0] pat, input logic [W2-1:0] prod);
    logic e_ldp, e_sh;
    a_bus = a;
    q_bus = q;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      e_ldp = (c >= 2 && c <= 8 && c % 2 == 0) ? pat[(c - 2) / 2] : 1'b0;
      e_sh  = (c >= 3 && c <= 9 && c % 2 == 1);
      chk("dir_ld_a", 32'(ld_a), 32'(c == 1));
      chk("dir_ld_p", 32'(ld_p), 32'(e_ldp));
      chk("dir_sh_pq", 32'(sh_pq), 32'(e_sh));
      chk("dir_done", 32'(done), 32'(c == 10));
      if (c == 10) chk("dir_product", 32'({p_r, q_r}), 32'(prod));
    end
    tick();
  endtask

  task automatic reset_mid_shift();
    bit found;
    int dones;
    found = 1'b0;
    dones = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sh_pq && iter == CW'(2)) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_shift_iter2", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1 chk("mid_reset_outputs", act_vec(), 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 2 * W + 4; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("no_done_after_abort", 32'(dones), 32'd0);
    chk("idle_iter_after_abort", 32'(iter), 32'd0);
    tick();
  endtask

  task automatic held_start();
    int loads, dcnt, d, l2, c;
    loads = 0; dcnt = 0; d = -1; l2 = -1;
    start = 1'b1;
`ifdef MULT_CTRL_DONE_HOLD_EN
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ld_a) loads++;
      if (done) break;
    end
    chk("held_single_load", 32'(loads), 32'd1);
    chk("held_done_seen", 32'(done), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_done_level", 32'(done), 32'd1);
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("hold_done_last", 32'(done), 32'd1);
    @(negedge clk);
    chk("hold_released_done", 32'(done), 32'd0);
    chk("hold_released_busy", 32'(busy), 32'd0);
    loads = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ld_a) loads++;
    end
    chk("hold_no_second_load", 32'(loads), 32'd0);
`else
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ld_a && d < 0) loads++;
      else if (ld_a && l2 < 0) l2 = c;
      if (done) begin
        dcnt++;
        if (d < 0) d = c;
      end
      if (l2 >= 0) break;
    end
    chk("held_single_load", 32'(loads), 32'd1);
    chk("held_done_one_cycle", 32'(dcnt), 32'd1);
    chk("retrigger_gap", 32'(l2 - d), 32'd2);
`endif
    drain();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_bus = '0;
    q_bus = '0;
    @(negedge clk);
    chk("reset_outputs", act_vec(), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    directed(4'd11, 4'b1101, 4'b1101, 8'd143);
    directed(4'd13, 4'd11, 4'b1011, 8'd143);
    reset_mid_shift();
    held_start();

    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
